// File: rtl/ofs_fim_pcie_ss_shims_pkg.sv
// Shared types for the PCIe SS TX shims.
//   t_tuser_seg      : one side-band header segment (vendor, hvalid, last_segment, hdr)
//   t_tuser_seg_vec  : the per-beat segment vector
//   t_tx_merge_state : arbiter state of the weighted TX merge
package ofs_fim_pcie_ss_shims_pkg;

    localparam int PCIE_SS_HDR_W      = 256;
    localparam int PCIE_SS_VENDOR_W   = 10;
    localparam int PCIE_SS_NUM_OF_SEG = 1;

    typedef struct packed {
        logic [PCIE_SS_VENDOR_W-1:0] vendor;
        logic                        hvalid;
        logic                        last_segment;
        logic [PCIE_SS_HDR_W-1:0]    hdr;
    } t_tuser_seg;

    // Bit position of hvalid inside a flattened segment (hdr is the LSB field).
    localparam int TUSER_HVALID_BIT = PCIE_SS_HDR_W + 1;

    typedef t_tuser_seg [PCIE_SS_NUM_OF_SEG-1:0] t_tuser_seg_vec;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } t_tx_merge_state;

endpackage

// File: rtl/ofs_fim_pcie_ss_skid_2x.sv
// Generic 2-entry skid buffer. in_ready depends only on occupancy, so the
// upstream handshake never sees a combinational path from out_ready.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/ready/data   : write side
//   out_valid/ready/data  : read side (data registered, visible the cycle after push)
module ofs_fim_pcie_ss_skid_2x #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;
    logic [1:0]   cnt;
    logic         push, pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Entries are cleared too so the sideband (e.g. channel id) reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ofs_fim_pcie_ss_tx_sb_wrr_merge.sv
// Packet-atomic weighted round-robin merge of NUM_CH side-band-header TX streams.
//   clk, rst_n           : clock, synchronous active-low reset
//   cfg_weight           : per-channel packet burst weight (0 disables the channel)
//   in_t*                : NUM_CH flattened AXI-S inputs
//   out_t*, out_ch       : merged AXI-S output plus source channel, from a 2-entry skid
//   err_sop_no_hvalid    : sticky, an SOP beat arrived with seg0 hvalid low
module ofs_fim_pcie_ss_tx_sb_wrr_merge
    import ofs_fim_pcie_ss_shims_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int TDATA_WIDTH = 512,
    parameter  int NUM_OF_SEG  = 1,
    parameter  int WEIGHT_W    = 4,
    localparam int USER_W      = NUM_OF_SEG * $bits(t_tuser_seg),
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH*WEIGHT_W-1:0]      cfg_weight,
    input  logic [NUM_CH-1:0]               in_tvalid,
    output logic [NUM_CH-1:0]               in_tready,
    input  logic [NUM_CH*TDATA_WIDTH-1:0]   in_tdata,
    input  logic [NUM_CH*TDATA_WIDTH/8-1:0] in_tkeep,
    input  logic [NUM_CH-1:0]               in_tlast,
    input  logic [NUM_CH*USER_W-1:0]        in_tuser,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic [TDATA_WIDTH-1:0]          out_tdata,
    output logic [TDATA_WIDTH/8-1:0]        out_tkeep,
    output logic                            out_tlast,
    output logic [USER_W-1:0]               out_tuser,
    output logic [CH_W-1:0]                 out_ch,
    output logic                            err_sop_no_hvalid
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int PW     = TDATA_WIDTH + KEEP_W + 1 + USER_W + CH_W;

    logic [WEIGHT_W-1:0]    weight  [NUM_CH];
    logic [TDATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [KEEP_W-1:0]      ch_keep [NUM_CH];
    logic [USER_W-1:0]      ch_user [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign weight[g]  = cfg_weight[g*WEIGHT_W +: WEIGHT_W];
        assign ch_data[g] = in_tdata[g*TDATA_WIDTH +: TDATA_WIDTH];
        assign ch_keep[g] = in_tkeep[g*KEEP_W +: KEEP_W];
        assign ch_user[g] = in_tuser[g*USER_W +: USER_W];
    end

    t_tx_merge_state     state_q, state_d;
    logic [CH_W-1:0]     hold_ch_q, hold_ch_d;
    logic [CH_W-1:0]     ptr_q, prev_ch_q;
    logic                prev_vld_q;
    logic [WEIGHT_W-1:0] wlat_q, burst_cnt_q;

    logic [CH_W-1:0]     pick, idx, sel;
    logic [CH_W:0]       sum;
    logic                pick_vld, sel_ok, sel_last, acc, sop, skid_rdy;
    logic                new_ch;
    logic [WEIGHT_W-1:0] sel_w, wlat_eff, cnt_nxt;

    // First eligible channel at or after ptr. Walking the offsets downward lets
    // the smallest offset overwrite the others.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
            idx = sum[CH_W-1:0];
            if (in_tvalid[idx] && weight[idx] != '0) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB;
            hold_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_ch_q <= hold_ch_d;
        end
    end

    // HOLD ignores weights so a packet whose channel gets disabled still completes.
    always_comb begin
        state_d   = state_q;
        hold_ch_d = hold_ch_q;
        sel       = pick;
        sel_ok    = pick_vld;
        if (state_q == HOLD) begin
            sel    = hold_ch_q;
            sel_ok = 1'b1;
        end
        in_tready = '0;
        if (rst_n && skid_rdy && sel_ok) in_tready[sel] = 1'b1;
        acc      = in_tvalid[sel] && in_tready[sel];
        sel_last = in_tlast[sel];
        if (acc) begin
            if (state_q == ARB && !sel_last) begin
                state_d   = HOLD;
                hold_ch_d = sel;
            end else if (state_q == HOLD && sel_last) begin
                state_d = ARB;
            end
        end
    end

    assign sop    = acc && (state_q == ARB);
    assign sel_w  = weight[sel];
    assign new_ch = !prev_vld_q || (sel != prev_ch_q);
    // A single-beat packet latches and finishes in the same cycle, so use the live weight.
    assign wlat_eff = (sop && new_ch) ? sel_w : wlat_q;
    assign cnt_nxt  = new_ch ? WEIGHT_W'(1) :
                      (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q             <= '0;
            prev_ch_q         <= '0;
            prev_vld_q        <= 1'b0;
            wlat_q            <= '0;
            burst_cnt_q       <= '0;
            err_sop_no_hvalid <= 1'b0;
        end else begin
            if (sop && new_ch) wlat_q <= sel_w;
            if (acc && sel_last) begin
                prev_ch_q  <= sel;
                prev_vld_q <= 1'b1;
                if (cnt_nxt >= wlat_eff) begin
                    ptr_q       <= (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
                    burst_cnt_q <= '0;
                end else begin
                    ptr_q       <= sel;
                    burst_cnt_q <= cnt_nxt;
                end
            end
            if (sop && !ch_user[sel][TUSER_HVALID_BIT]) err_sop_no_hvalid <= 1'b1;
        end
    end

    logic [PW-1:0] skid_din, skid_dout;

    assign skid_din = {ch_data[sel], ch_keep[sel], sel_last, ch_user[sel], sel};
    assign {out_tdata, out_tkeep, out_tlast, out_tuser, out_ch} = skid_dout;

    ofs_fim_pcie_ss_skid_2x #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (acc),
        .in_ready  (skid_rdy),
        .in_data   (skid_din),
        .out_valid (out_tvalid),
        .out_ready (out_tready),
        .out_data  (skid_dout)
    );

endmodule

// File: tb/tb_ofs_fim_pcie_ss_tx_sb_wrr_merge.sv
module tb_ofs_fim_pcie_ss_tx_sb_wrr_merge;
    import ofs_fim_pcie_ss_shims_pkg::*;

    localparam int NCH    = 4;
    localparam int DW     = 64;
    localparam int KW     = DW / 8;
    localparam int WW     = 4;
    localparam int USER_W = $bits(t_tuser_seg);

    logic                  clk = 1'b0, rst_n = 1'b0;
    logic [NCH*WW-1:0]     cfg_weight = '0;
    logic [NCH-1:0]        in_tvalid = '0, in_tready, in_tlast = '0;
    logic [NCH*DW-1:0]     in_tdata = '0;
    logic [NCH*KW-1:0]     in_tkeep = '0;
    logic [NCH*USER_W-1:0] in_tuser = '0;
    logic                  out_tvalid, out_tready = 1'b1, out_tlast, err_sop_no_hvalid;
    logic [DW-1:0]         out_tdata;
    logic [KW-1:0]         out_tkeep;
    logic [USER_W-1:0]     out_tuser;
    logic [1:0]            out_ch;

    ofs_fim_pcie_ss_tx_sb_wrr_merge #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .NUM_OF_SEG(1), .WEIGHT_W(WW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_weight(cfg_weight),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tkeep(in_tkeep),
        .in_tlast(in_tlast), .in_tuser(in_tuser),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata), .out_tkeep(out_tkeep),
        .out_tlast(out_tlast), .out_tuser(out_tuser), .out_ch(out_ch), .err_sop_no_hvalid(err_sop_no_hvalid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic [USER_W-1:0] user; int gap; } beat_t;
    typedef struct { int ch; logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic [USER_W-1:0] user; } exp_t;

    beat_t    chq [NCH][$];
    exp_t     expq[$];
    int       acc_cyc[$], obs_cyc[$];
    int       errors = 0, checks = 0, cyc = 0;
    logic     tog_en = 1'b0, masked_rdy_seen = 1'b0;
    logic [NCH-1:0] watch_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mk_data(int ch, int id);
        logic [31:0] a, b;
        a = 32'(ch) | 32'hC0DE_0000;
        b = 32'(id) ^ 32'h5A5A_A5A5;
        return {a, b};
    endfunction

    function automatic logic [KW-1:0] mk_keep(int id);
        return KW'(id * 37 + 1);
    endfunction

    function automatic logic [USER_W-1:0] mk_user(int ch, int id, logic last, logic hv);
        t_tuser_seg s;
        s.vendor       = 10'(id);
        s.hvalid       = hv;
        s.last_segment = last;
        s.hdr          = {224'(ch + 1), 32'(id * 3)};
        return s;
    endfunction

    task automatic add_pkt(input int ch, input int id0, input int n, input logic hv0, input int gap_at, input int gap_len);
        for (int b = 0; b < n; b++) begin
            beat_t x;
            x.data = mk_data(ch, id0 + b);
            x.keep = mk_keep(id0 + b);
            x.last = (b == n - 1);
            x.user = mk_user(ch, id0 + b, x.last, (b == 0) ? hv0 : 1'b1);
            x.gap  = (b == gap_at) ? gap_len : 0;
            chq[ch].push_back(x);
        end
    endtask

    task automatic exp_pkt(input int ch, input int id0, input int n, input logic hv0);
        for (int b = 0; b < n; b++) begin
            exp_t e;
            e.ch   = ch;
            e.data = mk_data(ch, id0 + b);
            e.keep = mk_keep(id0 + b);
            e.last = (b == n - 1);
            e.user = mk_user(ch, id0 + b, e.last, (b == 0) ? hv0 : 1'b1);
            expq.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        cfg_weight = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endtask

    task automatic rst_on();
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) chq[c].delete();
        expq.delete();
        acc_cyc.delete();
        obs_cyc.delete();
    endtask

    task automatic do_reset();
        rst_on();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats outstanding, want 0", name, expq.size());
        end
    endtask

    // Source model: AXI-S per channel, holds a beat until accepted; gap = idle cycles before a beat.
    initial begin
        logic [NCH-1:0] fire;
        bit             loaded [NCH];
        int             gapc   [NCH];
        for (int c = 0; c < NCH; c++) begin loaded[c] = 0; gapc[c] = 0; end
        forever begin
            @(negedge clk);
            fire = in_tvalid & in_tready;
            for (int c = 0; c < NCH; c++) if (fire[c]) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (!rst_n) begin
                    loaded[c]    = 0;
                    gapc[c]      = 0;
                    in_tvalid[c] = 1'b0;
                end else begin
                    if (fire[c] && chq[c].size() > 0) begin
                        void'(chq[c].pop_front());
                        loaded[c] = 0;
                    end
                    if (!loaded[c] && chq[c].size() > 0) begin
                        loaded[c] = 1;
                        gapc[c]   = chq[c][0].gap;
                    end
                    if (loaded[c] && gapc[c] > 0) begin
                        in_tvalid[c] = 1'b0;
                        gapc[c]--;
                    end else if (loaded[c]) begin
                        in_tvalid[c]               = 1'b1;
                        in_tdata[c*DW +: DW]       = chq[c][0].data;
                        in_tkeep[c*KW +: KW]       = chq[c][0].keep;
                        in_tlast[c]                = chq[c][0].last;
                        in_tuser[c*USER_W +: USER_W] = chq[c][0].user;
                    end else begin
                        in_tvalid[c] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) out_tready = ~out_tready;
        end
    end

    // Scoreboard monitor: one comparison per output handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (|(in_tready & watch_mask)) masked_rdy_seen = 1'b1;
            if (out_tvalid && out_tready) begin
                obs_cyc.push_back(cyc);
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got ch=%0d data=%h, want no beat", out_ch, out_tdata);
                end else begin
                    e = expq.pop_front();
                    if (int'(out_ch) != e.ch || out_tdata !== e.data || out_tkeep !== e.keep ||
                        out_tlast !== e.last || out_tuser !== e.user) begin
                        errors++;
                        $display("FAIL beat: got ch=%0d data=%h keep=%h last=%b hv=%b, want ch=%0d data=%h keep=%h last=%b hv=%b",
                                 out_ch, out_tdata, out_tkeep, out_tlast, out_tuser[TUSER_HVALID_BIT],
                                 e.ch, e.data, e.keep, e.last, e.user[TUSER_HVALID_BIT]);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [7] = '{0, 1, 1, 2, 2, 2, 3};
        int nid [NCH];
        int n;

        // Reset state
        rst_on();
        @(negedge clk);
        check("rst_out_tvalid", 64'(out_tvalid), 0);
        check("rst_in_tready", 64'(in_tready), 0);
        check("rst_out_ch", 64'(out_ch), 0);
        check("rst_err", 64'(err_sop_no_hvalid), 0);
        rst_n = 1'b1;

        // Single channel, 3-beat packet: one beat per clock, one cycle latency
        set_w(0, 0, 1, 0);
        exp_pkt(2, 100, 3, 1'b1);
        add_pkt(2, 100, 3, 1'b1, -1, 0);
        wait_drain("single", 50);
        check("single_acc_count", 64'(acc_cyc.size()), 3);
        check("single_obs_count", 64'(obs_cyc.size()), 3);
        if (acc_cyc.size() == 3 && obs_cyc.size() == 3)
            for (int i = 0; i < 3; i++) begin
                check($sformatf("single_latency%0d", i), 64'(obs_cyc[i]), 64'(acc_cyc[i] + 1));
                check($sformatf("single_stream%0d", i), 64'(obs_cyc[i]), 64'(obs_cyc[0] + i));
            end

        // Weighted RR {1,2,3,1}: two rounds of 0,1,1,2,2,2,3
        do_reset();
        set_w(1, 2, 3, 1);
        for (int c = 0; c < NCH; c++) nid[c] = 0;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 7; k++) begin
                exp_pkt(ord[k], 200 + 10 * ord[k] + nid[ord[k]], 1, 1'b1);
                nid[ord[k]]++;
            end
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < nid[c]; j++) add_pkt(c, 200 + 10 * c + j, 1, 1'b1, -1, 0);
        wait_drain("wrr", 200);

        // Atomicity: ch0 4-beat pkt with a 2-cycle gap before beat 2, ch1 busy, out_tready toggling
        do_reset();
        set_w(1, 1, 0, 0);
        exp_pkt(0, 300, 4, 1'b1);
        for (int j = 0; j < 3; j++) exp_pkt(1, 400 + j, 1, 1'b1);
        add_pkt(0, 300, 4, 1'b1, 2, 2);
        for (int j = 0; j < 3; j++) add_pkt(1, 400 + j, 1, 1'b1, -1, 0);
        tog_en = 1'b1;
        wait_drain("atomic", 200);
        tog_en = 1'b0;
        out_tready = 1'b1;

        // Masking {0,1,0,1}: only ch1/ch3 alternate
        do_reset();
        set_w(0, 1, 0, 1);
        masked_rdy_seen = 1'b0;
        watch_mask = 4'b0101;
        for (int j = 0; j < 3; j++) begin
            exp_pkt(1, 510 + j, 1, 1'b1);
            exp_pkt(3, 530 + j, 1, 1'b1);
        end
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < 3; j++) add_pkt(c, 500 + 10 * c + j, 1, 1'b1, -1, 0);
        wait_drain("mask", 200);
        repeat (5) @(negedge clk);
        check("mask_ready_seen", 64'(masked_rdy_seen), 0);
        check("mask_ch0_left", 64'(chq[0].size()), 3);
        check("mask_ch2_left", 64'(chq[2].size()), 3);
        watch_mask = '0;

        // Weight change mid-burst: ch0 3 -> 1 after its first packet
        do_reset();
        set_w(3, 1, 0, 0);
        exp_pkt(0, 600, 1, 1'b1); exp_pkt(0, 601, 1, 1'b1); exp_pkt(0, 602, 1, 1'b1);
        exp_pkt(1, 700, 1, 1'b1); exp_pkt(0, 603, 1, 1'b1); exp_pkt(1, 701, 1, 1'b1);
        exp_pkt(0, 604, 1, 1'b1); exp_pkt(1, 702, 1, 1'b1);
        for (int j = 0; j < 5; j++) add_pkt(0, 600 + j, 1, 1'b1, -1, 0);
        for (int j = 0; j < 3; j++) add_pkt(1, 700 + j, 1, 1'b1, -1, 0);
        n = 0;
        while (chq[0].size() == 5 && n < 50) begin @(negedge clk); n++; end
        check("wchg_first_accept", 64'(chq[0].size() < 5), 1);
        set_w(1, 1, 0, 0);
        wait_drain("wchg", 200);

        // SOP without hvalid: flag next cycle, beat forwarded unchanged
        do_reset();
        set_w(1, 1, 0, 1);
        exp_pkt(1, 800, 1, 1'b0);
        add_pkt(1, 800, 1, 1'b0, -1, 0);
        n = 0;
        @(negedge clk);
        while (!(in_tvalid[1] && in_tready[1]) && n < 50) begin @(negedge clk); n++; end
        check("err_before", 64'(err_sop_no_hvalid), 0);
        @(negedge clk);
        check("err_after", 64'(err_sop_no_hvalid), 1);
        wait_drain("err_beat", 50);

        // Reset mid-packet with the skid holding beats
        out_tready = 1'b0;
        add_pkt(0, 810, 3, 1'b1, -1, 0);
        repeat (6) @(negedge clk);
        check("stall_out_tvalid", 64'(out_tvalid), 1);
        rst_on();
        @(negedge clk);
        check("midrst_out_tvalid", 64'(out_tvalid), 0);
        check("midrst_err", 64'(err_sop_no_hvalid), 0);
        check("midrst_in_tready", 64'(in_tready), 0);
        rst_n = 1'b1;
        out_tready = 1'b1;
        // ptr was 2 before reset; cleared ptr means ch0 wins over ch3
        exp_pkt(0, 900, 1, 1'b1);
        exp_pkt(3, 901, 1, 1'b1);
        add_pkt(0, 900, 1, 1'b1, -1, 0);
        add_pkt(3, 901, 1, 1'b1, -1, 0);
        wait_drain("post_rst", 50);

        // All weights 0: nothing accepted, output stays idle
        do_reset();
        set_w(0, 0, 0, 0);
        for (int c = 0; c < NCH; c++) add_pkt(c, 950 + c, 1, 1'b1, -1, 0);
        repeat (8) @(negedge clk);
        check("zero_w_out_tvalid", 64'(out_tvalid), 0);
        check("zero_w_in_tready", 64'(in_tready), 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
